// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - sequential signed radix-4 Booth multiplier (optional early exit: BOOTH_SKIP_ZERO_EN)

// Forms one sign-extended Booth partial product from a 3-bit recoding window.
module calc_partial_product #(
    parameter int WORD_LEN = 8
) (
    input  logic [2:0]            i_opcode,
    input  logic [WORD_LEN-1:0]   i_multiplicand,
    output logic [2*WORD_LEN-1:0] o_partial_product
);

    logic [2*WORD_LEN-1:0] mcand_ext;

    // Select 0, +-M or +-2M; negation is done at full product width so -2*MIN fits.
    always_comb begin
        mcand_ext         = {{WORD_LEN{i_multiplicand[WORD_LEN-1]}}, i_multiplicand};
        o_partial_product = '0;
        case (i_opcode)
            3'b001, 3'b010: o_partial_product = mcand_ext;
            3'b011:         o_partial_product = mcand_ext << 1;
            3'b100:         o_partial_product = '0 - (mcand_ext << 1);
            3'b101, 3'b110: o_partial_product = '0 - mcand_ext;
            default:        o_partial_product = '0;
        endcase
    end

endmodule

// Walks the multiplier two bits per cycle and accumulates shifted partial products.
module booth_seq_multiplier #(
    parameter int WORD_LEN = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [WORD_LEN-1:0]   i_multiplicand,
    input  logic [WORD_LEN-1:0]   i_multiplier,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2*WORD_LEN-1:0] o_product
);

    localparam int STEPS  = WORD_LEN / 2;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int PROD_W = 2 * WORD_LEN;

    generate
        if ((WORD_LEN % 2) != 0 || WORD_LEN < 4) begin : g_bad_word_len
            $error("booth_seq_multiplier: WORD_LEN must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_LEN-1:0] mcand_q, mcand_d;
    // Multiplier with the implicit bit -1 at position 0; shifted right by 2 each step.
    logic [WORD_LEN:0]   mplr_q, mplr_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [PROD_W-1:0]   prod_q, prod_d;

    logic [PROD_W-1:0]   partial_product;
    logic [PROD_W-1:0]   pp_shifted;
    logic [WORD_LEN:0]   mplr_shift;
    logic                last_step;
    logic                calc_done;

    calc_partial_product #(
        .WORD_LEN (WORD_LEN)
    ) u_calc_partial_product (
        .i_opcode          (mplr_q[2:0]),
        .i_multiplicand    (mcand_q),
        .o_partial_product (partial_product)
    );

    // Step datapath: weight the partial product and advance the recoding window.
    always_comb begin
        pp_shifted = partial_product << {step_q, 1'b0};
        mplr_shift = {{2{mplr_q[WORD_LEN]}}, mplr_q[WORD_LEN:2]};
        last_step  = (step_q == STEP_W'(STEPS - 1));
    end

`ifdef BOOTH_SKIP_ZERO_EN
    logic rest_uniform;

    // Remaining multiplier bits all equal means every later opcode is 000/111.
    always_comb begin
        rest_uniform = (&mplr_shift) | ~(|mplr_shift);
        calc_done    = last_step | rest_uniform;
    end
`else
    // Fixed latency: finish only after the final step.
    always_comb begin
        calc_done = last_step;
    end
`endif

    // Next-state and datapath updates for the handshake FSM.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        step_d  = step_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    mcand_d = i_multiplicand;
                    mplr_d  = {i_multiplier, 1'b0};
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d  = acc_q + pp_shifted;
                mplr_d = mplr_shift;
                step_d = step_q + STEP_W'(1);
                if (calc_done) begin
                    prod_d  = acc_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            prod_q  <= prod_d;
        end
    end

    // Handshake flags are pure state decodes so reset drops o_valid immediately.
    always_comb begin
        o_ready   = (state_q == IDLE);
        o_valid   = (state_q == DONE);
        o_product = prod_q;
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - directed self-checking bench for booth_seq_multiplier

module tb_booth_seq_multiplier;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_multiplicand;
    logic [7:0]  i_multiplier;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_product;

    int checks = 0;
    int errors = 0;

    booth_seq_multiplier #(
        .WORD_LEN (8)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_multiplicand (i_multiplicand),
        .i_multiplier   (i_multiplier),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_product      (o_product)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands, wait for o_ready, return #1 after the accepting edge.
    task automatic start(input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge i_clk);
        i_multiplicand = a;
        i_multiplier   = b;
        i_valid        = 1'b1;
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check("ready_before_accept", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_valid        = 1'b0;
        i_multiplicand = 8'hA5;
        i_multiplier   = 8'h5A;
        check("ready_low_after_accept", 32'(o_ready), 32'd0);
    endtask

    // Count edges until o_valid; check latency, busy flag and product.
    task automatic wait_result(input string tag, input logic [15:0] exp_prod,
                               input int lat_fixed, input int lat_skip);
        int n;
        int exp_lat;
`ifdef BOOTH_SKIP_ZERO_EN
        exp_lat = lat_skip;
`else
        exp_lat = lat_fixed;
`endif
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge i_clk);
            #1;
            n++;
            if (!o_valid) check({tag, "_busy"}, 32'(o_ready), 32'd0);
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_product"}, 32'(o_product), 32'(exp_prod));
    endtask

    task automatic release_result(input logic [15:0] prev);
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("release_valid", 32'(o_valid), 32'd0);
        check("release_ready", 32'(o_ready), 32'd1);
        check("release_hold_product", 32'(o_product), 32'(prev));
        @(negedge i_clk);
        i_ready = 1'b0;
    endtask

    initial begin
        // Reset held with random inputs.
        i_rst_n        = 1'b0;
        i_valid        = 1'($urandom);
        i_ready        = 1'($urandom);
        i_multiplicand = 8'($urandom);
        i_multiplier   = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            i_valid        = 1'($urandom);
            i_multiplicand = 8'($urandom);
            check("rst_valid", 32'(o_valid), 32'd0);
            check("rst_ready", 32'(o_ready), 32'd1);
            check("rst_product", 32'(o_product), 32'h0);
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        check("post_rst_valid", 32'(o_valid), 32'd0);
        check("post_rst_ready", 32'(o_ready), 32'd1);
        check("post_rst_product", 32'(o_product), 32'h0);

        // Basic and extreme operands.
        start(8'h03, 8'h05);
        wait_result("3x5", 16'h000F, 4, 2);
        release_result(16'h000F);

        start(8'h80, 8'h80);
        wait_result("m128xm128", 16'h4000, 4, 4);
        release_result(16'h4000);

        start(8'h80, 8'h7F);
        wait_result("m128x127", 16'hC080, 4, 4);
        release_result(16'hC080);

        start(8'h00, 8'hB3);
        wait_result("0xm77", 16'h0000, 4, 4);
        release_result(16'h0000);

        start(8'hFF, 8'hFF);
        wait_result("m1xm1", 16'h0001, 4, 1);

        // Backpressure: new pair offered during DONE must not be taken.
        @(negedge i_clk);
        i_multiplicand = 8'h07;
        i_multiplier   = 8'h09;
        i_valid        = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk);
            #1;
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_ready", 32'(o_ready), 32'd0);
            check("bp_product", 32'(o_product), 32'h0001);
        end
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("bp_release_valid", 32'(o_valid), 32'd0);
        check("bp_release_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        i_ready = 1'b0;
        @(posedge i_clk);
        #1;
        check("bp_accept_ready", 32'(o_ready), 32'd0);
        i_valid        = 1'b0;
        i_multiplicand = 8'h33;
        i_multiplier   = 8'hCC;
        wait_result("7x9", 16'h003F, 4, 3);
        release_result(16'h003F);

        // Asynchronous reset during the second CALC cycle.
        start(8'h64, 8'hFD);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd1);
        check("midrst_product", 32'(o_product), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge i_clk);
            #1;
            check("midrst_no_valid", 32'(o_valid), 32'd0);
        end

        // Early-termination cases (fixed latency without the option).
        start(8'h19, 8'h01);
        wait_result("25x1", 16'h0019, 4, 1);
        release_result(16'h0019);

        start(8'h19, 8'hFF);
        wait_result("25xm1", 16'hFFE7, 4, 1);
        release_result(16'hFFE7);

        start(8'h19, 8'h40);
        wait_result("25x64", 16'h0640, 4, 4);
        release_result(16'h0640);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Sequential signed radix-4 Booth multiplier built around one `calc_partial_product` instance.
- Upstream role: each cycle it walks the multiplier two bits at a time and forms the 3-bit opcode.
- Downstream role: it shifts the returned sign-extended partial product and accumulates it into a 2*WORD_LEN result.
- Operands arrive and results leave over valid/ready handshakes.

Parameters:
- WORD_LEN, 8, operand width in bits. Must be even and >= 4; an odd value is an elaboration error. STEPS = WORD_LEN/2.

Ports:
- i_clk  input  1  clock, rising-edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  operand pair valid.
- o_ready  output  1  block can accept operands.
- i_multiplicand  input  WORD_LEN  signed two's-complement multiplicand.
- i_multiplier  input  WORD_LEN  signed two's-complement multiplier.
- o_valid  output  1  o_product valid.
- i_ready  input  1  consumer accepts product.
- o_product  output  2*WORD_LEN  signed product.

Behaviour:
- Reset (async assert, any state): state=IDLE, accumulator=0, step counter=0, o_valid=0, o_product=0. o_ready=1 while i_rst_n is low and after release.
- States: IDLE, CALC, DONE. o_ready=1 only in IDLE. o_valid=1 only in DONE.
- IDLE:
  - On i_valid&&o_ready at an edge: latch the multiplicand, and the multiplier extended with an implicit bit -1 = 0.
  - Clear the accumulator and step counter, then go to CALC.
- CALC step k (k=0..STEPS-1):
  - opcode = {mplr[2k+1], mplr[2k], mplr[2k-1]}; mplr[-1]=0.
  - Feed the opcode and the latched multiplicand to `calc_partial_product`.
  - accumulator += partial_product << 2k, truncated to 2*WORD_LEN bits (wrap is intentional; the result is exact for all signed inputs).
  - Implementation uses a right-shifting multiplier register (shift by 2 per step) and a left shift on the partial product. No multiply operator.
  - Transition to DONE after the step k=STEPS-1.
- Latency: o_valid rises exactly STEPS cycles after the accepting edge (4 for WORD_LEN=8).
- DONE:
  - o_product = accumulator, held stable while i_ready=0.
  - On i_valid... ignored. On o_valid&&i_ready at an edge, go to IDLE with o_valid=0. o_product keeps its last value until the next DONE.
  - Minimum issue interval is STEPS+2 cycles; there is no same-cycle DONE->accept bypass.
- i_valid during CALC/DONE: ignored, not queued. The upstream block must hold data until o_ready.
- Operand inputs are sampled only at the accepting edge. Later changes have no effect.
- Reset mid-CALC or mid-DONE: the result is lost, with no spurious o_valid after release.

Optional Feature:
- Macro: BOOTH_SKIP_ZERO_EN.
- Defined: early termination.
  - After step k completes, check whether mplr bits [WORD_LEN-1 : 2k+1] are all equal. If so, every remaining opcode is 000/111 and contributes zero, so go to DONE immediately.
  - At least one step is always performed. Latency becomes variable, 1..STEPS cycles; the result is identical.
- Undefined: fixed STEPS-cycle latency, and no uniformity-check logic is synthesised.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs -> o_valid=0, o_ready=1, o_product=0x0000. Release -> unchanged until a handshake.
- 3 x 5, WORD_LEN=8 -> o_valid high exactly 4 cycles after the accept edge, o_product=0x000F. o_ready=0 during those 4 cycles.
- Extremes: -128 x -128 -> 0x4000; -128 x 127 -> 0xC080; -1 x -1 -> 0x0001; 0 x -77 -> 0x0000.
- Backpressure: hold i_ready=0 for 6 cycles after o_valid, and drive i_valid=1 with 7 x 9 during DONE -> o_product stays at the prior result and the new pair is not accepted. Raise i_ready -> IDLE next cycle, then 7 x 9 is accepted and gives 0x003F.
- Reset mid-operation: start 100 x -3, pull i_rst_n low in the 2nd CALC cycle (asynchronously, between edges) -> o_valid=0 and o_ready=1 immediately. After release, no o_valid appears until a new handshake.
- BOOTH_SKIP_ZERO_EN defined:
  - 25 x 1 -> o_valid 1 cycle after accept, 0x0019.
  - 25 x -1 -> 1 cycle, 0xFFE7.
  - 25 x 0x40 -> 4 cycles, 0x0640.
- Same 25 x 1 case without the macro -> 4 cycles, same values.
